// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared instruction-memory widths and arbiter FSM state encoding
package imem_arbiter_pkg;
  localparam int ADR_BIT = 16;
  localparam int ISC_BIT = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/imem_ld_port.sv
// imem_ld_port: loader handshake, saturating write counter and read-back pipeline (IMEM_ARB_READBACK_EN); ports grant/clr from FSM, ld_* loader side, req_* BRAM request, rom_dout read data
module imem_ld_port #(
  parameter int ADR_W = 16,
  parameter int ISC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant,
  input  logic             clr,
  input  logic             ld_valid,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_addr,
  input  logic [ISC_W-1:0] ld_data,
  input  logic [ISC_W-1:0] rom_dout,
  output logic             ld_ready,
  output logic             ld_rvalid,
  output logic [ISC_W-1:0] ld_rdata,
  output logic [CNT_W-1:0] ld_count,
  output logic             req_en,
  output logic             req_we,
  output logic [ADR_W-1:0] req_addr,
  output logic [ISC_W-1:0] req_din
);
  logic acc;
  assign acc = ld_valid & ld_ready;
  assign req_en = acc;
  assign req_addr = ld_addr;
  assign req_din = ld_data;
`ifdef IMEM_ARB_READBACK_EN
  logic rd_pend;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_pend <= 1'b0;
    else rd_pend <= acc & ~ld_we;
  assign ld_ready = grant & ~rst & ~rd_pend;
  assign req_we = acc & ld_we;
  assign ld_rvalid = rd_pend;
  assign ld_rdata = rd_pend ? rom_dout : '0;
`else
  logic unused_rd;
  assign unused_rd = ^{ld_we, rom_dout};
  assign ld_ready = grant & ~rst;
  assign req_we = acc;
  assign ld_rvalid = 1'b0;
  assign ld_rdata = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) ld_count <= '0;
    else if (clr) ld_count <= '0;
    else if (req_we & ~&ld_count) ld_count <= ld_count + 1'b1;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction BRAM port between CPU fetch (fetch_*, isc_valid) and the program loader (ld_*), drives ROM_* pins; optional read-back via IMEM_ARB_READBACK_EN
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADR_W = ADR_BIT,
  parameter int ISC_W = ISC_BIT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_CPU,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [ADR_W-1:0] fetch_pc,
  output logic             fetch_ena_n,
  output logic             isc_valid,
  output logic             cpu_halted,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_addr,
  input  logic [ISC_W-1:0] ld_data,
  output logic [ISC_W-1:0] ld_rdata,
  output logic             ld_rvalid,
  output logic [CNT_W-1:0] ld_count,
  output logic             ROM_clk,
  output logic             ROM_rst,
  output logic             ROM_en,
  output logic             ROM_we,
  output logic [ADR_W-1:0] ROM_addr,
  output logic [ISC_W-1:0] ROM_din,
  input  logic [ISC_W-1:0] ROM_dout
);
  state_t state, nxt;
  logic run, req_en, req_we;
  logic [ADR_W-1:0] req_addr;
  imem_ld_port #(.ADR_W(ADR_W), .ISC_W(ISC_W), .CNT_W(CNT_W)) u_ld (
    .clk(clk), .rst(rst), .grant(state == IDLE), .clr(state == DRAIN),
    .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .rom_dout(ROM_dout), .ld_ready(ld_ready), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata), .ld_count(ld_count), .req_en(req_en), .req_we(req_we),
    .req_addr(req_addr), .req_din(ROM_din)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? ((enable_CPU & ~ld_valid) ? RUN : IDLE)
        : state == RUN  ? ((ld_valid | ~enable_CPU) ? DRAIN : RUN)
        : IDLE;
    run = state == RUN;
    fetch_ena_n = ~run | stall;
    ROM_en = ~rst & (run ? ~fetch_ena_n : req_en);
    ROM_we = ~rst & ~run & req_we;
    ROM_addr = run ? fetch_pc : req_addr;
  end
  assign cpu_halted = ~run;
  assign ROM_clk = clk;
  assign ROM_rst = rst | (branch_taken & run);
  always_ff @(posedge clk or posedge rst)
    if (rst) isc_valid <= 1'b0;
    else isc_valid <= run & ROM_en & ~ROM_rst;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench with behavioural BRAM and reference model
module tb_imem_arbiter;
  localparam int AW = 16, IW = 32, CW = 16;
  logic clk = 0, rst = 1, enable_CPU = 0, stall = 0, branch_taken = 0;
  logic ld_valid = 0, ld_we = 0;
  logic [AW-1:0] fetch_pc = 0, ld_addr = 0;
  logic [IW-1:0] ld_data = 0;
  logic fetch_ena_n, isc_valid, cpu_halted, ld_ready, ld_rvalid;
  logic [IW-1:0] ld_rdata, ROM_din, ROM_dout;
  logic [CW-1:0] ld_count;
  logic ROM_clk, ROM_rst, ROM_en, ROM_we;
  logic [AW-1:0] ROM_addr;
  always #5 clk = ~clk;

  imem_arbiter #(.ADR_W(AW), .ISC_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable_CPU(enable_CPU), .stall(stall),
    .branch_taken(branch_taken), .fetch_pc(fetch_pc), .fetch_ena_n(fetch_ena_n),
    .isc_valid(isc_valid), .cpu_halted(cpu_halted), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ld_count(ld_count),
    .ROM_clk(ROM_clk), .ROM_rst(ROM_rst), .ROM_en(ROM_en), .ROM_we(ROM_we),
    .ROM_addr(ROM_addr), .ROM_din(ROM_din), .ROM_dout(ROM_dout)
  );

  // behavioural single-port BRAM, 64 words, 1-cycle read, output register cleared by ROM_rst
  logic [IW-1:0] bmem [0:63];
  always @(posedge ROM_clk)
    if (ROM_rst) ROM_dout <= '0;
    else if (ROM_en) begin
      if (ROM_we) bmem[ROM_addr[5:0]] <= ROM_din;
      else ROM_dout <= bmem[ROM_addr[5:0]];
    end

  typedef struct {
    logic fena_n, iv, halted, ready, rvalid, en, we, rrst, dchk;
    logic [IW-1:0] rdata, din, dout;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t q[$];

  // reference model: owner of the port (0 loader, 1 cpu, 2 hand-over), memory image, counters
  int owner = 0, cnt = 0, checks = 0, errors = 0;
  bit iv = 0, rdp = 0;
  logic [IW-1:0] iv_data = 0, rd_data = 0;
  logic [IW-1:0] ref_mem [0:63];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input bit r, en, st, br, input int pc, input bit lv, lwe, input int la, input logic [IW-1:0] ld);
    exp_t e;
    bit run, rdy, acc, wr, rd;
    @(posedge clk);
    #1;
    rst = r; enable_CPU = en; stall = st; branch_taken = br;
    fetch_pc = AW'(pc); ld_valid = lv; ld_we = lwe; ld_addr = AW'(la); ld_data = ld;
    if (r) begin owner = 0; cnt = 0; iv = 0; rdp = 0; end
    run = owner == 1;
    rdy = owner == 0 && !r && !rdp;
    acc = lv && rdy;
`ifdef IMEM_ARB_READBACK_EN
    wr = acc && lwe;
    rd = acc && !lwe;
`else
    wr = acc;
    rd = 0;
`endif
    e.halted = !run; e.fena_n = !run || st; e.ready = rdy;
    e.en = run ? (!st && !r) : acc; e.we = wr; e.rrst = r || (br && run);
    e.addr = run ? AW'(pc) : AW'(la); e.din = ld;
    e.iv = iv; e.dchk = iv; e.dout = iv_data;
    e.rvalid = rdp; e.rdata = rdp ? rd_data : '0; e.cnt = CW'(cnt);
    q.push_back(e);
    iv = run && e.en && !e.rrst;
    iv_data = ref_mem[pc[5:0]];
    rdp = rd;
    rd_data = ref_mem[la[5:0]];
    if (wr) begin ref_mem[la[5:0]] = ld; if (cnt < 65535) cnt++; end
    if (owner == 2) cnt = 0;
    owner = r ? 0 : owner == 0 ? ((en && !lv) ? 1 : 0) : owner == 1 ? ((lv || !en) ? 2 : 1) : 0;
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("cpu_halted", 32'(cpu_halted), 32'(e.halted));
      chk("fetch_ena_n", 32'(fetch_ena_n), 32'(e.fena_n));
      chk("ld_ready", 32'(ld_ready), 32'(e.ready));
      chk("ROM_en", 32'(ROM_en), 32'(e.en));
      chk("ROM_we", 32'(ROM_we), 32'(e.we));
      chk("ROM_rst", 32'(ROM_rst), 32'(e.rrst));
      chk("isc_valid", 32'(isc_valid), 32'(e.iv));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(e.rvalid));
      chk("ld_rdata", ld_rdata, e.rdata);
      chk("ld_count", 32'(ld_count), 32'(e.cnt));
      if (e.en) chk("ROM_addr", 32'(ROM_addr), 32'(e.addr));
      if (e.we) chk("ROM_din", ROM_din, e.din);
      if (e.dchk) chk("ROM_dout", ROM_dout, e.dout);
    end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 0, 1, 1, i, $urandom);
    // reset release straight into RUN, fetch 0x0004
    step(1, 1, 0, 0, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4, 0, 0, 0, 0);
    // loader burst of 8 words, then fetch 0x0003
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 1, i, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3, 0, 0, 0, 0);
    // loader preempts running CPU
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 9, 1, 1, 20, $urandom);
    // branch flush during stall, then plain branch
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 5, 0, 0, 0, 0);
    step(0, 1, 1, 1, 6, 0, 0, 0, 0);
    step(0, 1, 1, 0, 6, 0, 0, 0, 0);
    step(0, 1, 0, 1, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 7, 0, 0, 0, 0);
    // reset asserted mid-write
    step(0, 0, 0, 0, 0, 1, 1, 30, 32'h1234_5678);
    step(1, 0, 0, 0, 0, 1, 1, 31, 32'hCAFE_F00D);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // read-back of 0x0010 (plain write when read-back is compiled out)
    step(0, 0, 0, 0, 0, 1, 1, 16, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 1, 0, 16, 0);
    step(0, 0, 0, 0, 0, 1, 0, 16, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
           $urandom_range(7) == 0, $urandom_range(63), $urandom_range(2) == 0,
           $urandom_range(1) == 1, $urandom_range(63), $urandom);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
